// File: rtl/hazard_controller.sv
// Hazard controller: forwarding selects, load-use stalls, branch flushes,
// memory-wait freeze with watchdog. Optional counters under HAZARD_PERF_EN.
module hazard_controller #(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       ResultSrcE0,
    input  logic       PCSrcE,
    input  logic       MemReqM,
    input  logic       MemReadyM,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushW,
    output logic       mem_timeout
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
`endif
);

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [7:0] WMAX = 8'(WAIT_MAX);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       tmo_q, tmo_d;
    logic       lw_stall;
    logic       wait_c;
    logic       run_eq;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic       wm,
                                           input logic [4:0] rdm,
                                           input logic       ww,
                                           input logic [4:0] rdw);
        if (wm && rdm != 5'd0 && rdm == rs)
            return 2'b10;
        else if (ww && rdw != 5'd0 && rdw == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
    assign ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);

    assign lw_stall = ResultSrcE0 & (RdE != 5'd0) &
                      ((RdE == Rs1D) | (RdE == Rs2D)) & ~PCSrcE;

    always_comb begin
        state_d = INIT;
        wait_c  = 1'b0;
        run_eq  = 1'b0;
        StallF  = 1'b0;
        StallD  = 1'b0;
        StallE  = 1'b0;
        StallM  = 1'b0;
        FlushD  = 1'b0;
        FlushE  = 1'b0;
        FlushW  = 1'b0;
        unique case (state_q)
            INIT: begin
                FlushD  = 1'b1;
                FlushE  = 1'b1;
                FlushW  = 1'b1;
                state_d = RUN;
            end
            RUN:      wait_c = MemReqM & ~MemReadyM;
            MEM_WAIT: wait_c = ~MemReadyM;
            default:  state_d = INIT;
        endcase
        // Freeze wins over branch flush and load-use stall
        if (state_q == RUN || state_q == MEM_WAIT) begin
            if (wait_c) begin
                StallF  = 1'b1;
                StallD  = 1'b1;
                StallE  = 1'b1;
                StallM  = 1'b1;
                FlushW  = 1'b1;
                state_d = MEM_WAIT;
            end else begin
                run_eq  = 1'b1;
                StallF  = lw_stall;
                StallD  = lw_stall;
                FlushD  = PCSrcE;
                FlushE  = lw_stall | PCSrcE;
                state_d = RUN;
            end
        end
    end

    always_comb begin
        cnt_d = 8'd0;
        if (wait_c)
            cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        tmo_d = tmo_q | (wait_c & (cnt_d >= WMAX));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= INIT;
            cnt_q   <= 8'd0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    assign mem_timeout = tmo_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (StallF)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (run_eq && FlushE)
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;
`else
    logic unused_run_eq;
    assign unused_run_eq = run_eq;
`endif

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard controller for the five-stage pipelined RISC-V core. It provides forwarding selects, load-use stalls, branch/jump flushes and a post-reset flush. It also runs a stall sequencer that freezes the whole pipeline while a data-memory access in Memory stage is not ready, with a watchdog on that wait. It sits beside the datapath and drives the enable/clear inputs of the F/D/E/M/W pipeline registers.

## Interface
Parameters:
- WAIT_MAX, 15, memory-wait cycles tolerated before `mem_timeout` is set (1..255)

Ports:
- clk  in  1  core clock, rising-edge
- reset  in  1  asynchronous, active-high
- Rs1D, Rs2D  in  5  source registers in Decode
- Rs1E, Rs2E, RdE  in  5  source/destination registers in Execute
- RdM, RdW  in  5  destination registers in Memory/Writeback
- RegWriteM, RegWriteW  in  1  register-write enables in Memory/Writeback
- ResultSrcE0  in  1  instruction in Execute is a load
- PCSrcE  in  1  taken branch/jump resolved in Execute
- MemReqM  in  1  load/store active in Memory
- MemReadyM  in  1  data memory completes access this cycle
- ForwardAE, ForwardBE  out  2  00 = register file, 01 = ResultW, 10 = ALUResultM
- StallF, StallD, StallE, StallM  out  1  hold pipeline register
- FlushD, FlushE, FlushW  out  1  clear pipeline register to bubble
- mem_timeout  out  1  sticky; memory wait exceeded WAIT_MAX

## Operation
- Forwarding (combinational, per source):
  - 10 if RegWriteM, RdM != 0 and RdM == Rs1E (resp. Rs2E).
  - Else 01 if RegWriteW, RdW != 0 and RdW == RsE.
  - Else 00.
  - Memory stage has priority over Writeback.
- lwStall = ResultSrcE0 & RdE != 0 & (RdE == Rs1D | RdE == Rs2D) & ~PCSrcE.
- State machine, 2-bit register:
  - INIT (reset state):
    - FlushD = FlushE = FlushW = 1; all stalls 0.
    - Next state RUN unconditionally.
  - RUN:
    - StallF = StallD = lwStall.
    - FlushD = PCSrcE.
    - FlushE = lwStall | PCSrcE.
    - StallE = StallM = FlushW = 0.
    - If MemReqM & ~MemReadyM, go to MEM_WAIT this cycle. Outputs are already the freeze set this cycle, combinational on MemReadyM.
  - MEM_WAIT:
    - StallF = StallD = StallE = StallM = 1; FlushW = 1 (bubble into W).
    - FlushD = FlushE = 0. PCSrcE and lwStall are ignored: Execute is frozen, so they re-evaluate on exit.
    - When MemReadyM = 1, outputs revert to RUN equations in the same cycle and next state is RUN.
- Wait counter, 8-bit:
  - Cleared in RUN/INIT; increments each MEM_WAIT cycle, saturating at 255.
  - `mem_timeout` is set when the counter reaches WAIT_MAX while still waiting.
  - It is cleared only by reset; the pipeline keeps waiting after it is set.
- Freeze priority: memory freeze > branch flush > load-use stall.
- lwStall and PCSrcE cannot truly coincide (a load is not a branch). Gating lwStall with ~PCSrcE guarantees PCSrcE wins.

## Timing
- All reset values:
  - State = INIT, wait counter = 0, mem_timeout = 0.
  - Outputs in INIT: flushes 1, stalls 0, forwards 00.
- Reset asserted mid-MEM_WAIT:
  - Immediate return to INIT; the counter and mem_timeout clear asynchronously.
- Forwarding and RUN/MEM_WAIT stall outputs are combinational from inputs plus state, with zero-cycle latency.
- One-cycle costs:
  - A load-use hazard costs exactly 1 stall cycle.
  - A taken branch costs 2 bubbles (D and E flushed in one cycle).
- MEM_WAIT duration equals the number of cycles with MemReadyM = 0; a ready-on-first-cycle access causes no freeze.
- MemReqM dropping while in MEM_WAIT is a protocol error. The controller stays frozen until MemReadyM.

## Configuration
- HAZARD_PERF_EN:
  - When defined, adds output ports `stall_cycles` (32) and `flush_events` (32), reset to 0.
  - `stall_cycles` increments every cycle StallF = 1.
  - `flush_events` increments every cycle FlushE = 1 in RUN.
  - Both wrap modulo 2^32.
  - When undefined, neither the ports nor the counters exist and behaviour is otherwise identical.

## Test plan
- Reset held 22 ns then released -> first cycle after release FlushD/E/W = 1, then RUN with all stalls 0 and ForwardAE = ForwardBE = 00.
- `add x5` in Memory and `add x6` in Writeback both writing, Rs1E = x5, Rs2E = x6 -> ForwardAE = 10, ForwardBE = 01. With RdM = RdW = 0 -> 00.
- `lw x7` in Execute with Rs2D = x7 -> exactly one cycle of StallF = StallD = FlushE = 1, then normal flow. With RdE = x0 -> no stall.
- PCSrcE = 1 in RUN -> FlushD = FlushE = 1 for one cycle, StallF = 0. With a simultaneous lwStall condition -> flush outputs only.
- MemReqM = 1, MemReadyM low for 4 cycles -> 4 cycles all Stall* = 1 and FlushW = 1, counter reaches 4, mem_timeout stays 0, RUN resumes on the ready cycle. Repeat with 20 cycles low -> mem_timeout = 1 from cycle 15 until reset.
- With HAZARD_PERF_EN: one load-use stall plus one branch -> stall_cycles = 1, flush_events = 2.
